// File: rtl/squash_arbiter_l6.sv
// Squash arbiter for the L6 execute stage: picks the oldest squash relative to the
// in-flight head and holds it in one pending register. Optional stats via SQUASH_ARB_STATS_EN.
module squash_arbiter_l6 #(
  parameter int p_num_req      = 2,
  parameter int p_seq_num_bits = 5,
  parameter int p_target_bits  = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [p_seq_num_bits-1:0]           head_seq_num,
  input  logic [p_num_req-1:0]                req_val,
  input  logic [p_num_req*p_target_bits-1:0]  req_target,
  input  logic [p_num_req*p_seq_num_bits-1:0] req_seq_num,
  output logic                                sq_val,
  input  logic                                sq_rdy,
  output logic [p_target_bits-1:0]            sq_target,
  output logic [p_seq_num_bits-1:0]           sq_seq_num
`ifdef SQUASH_ARB_STATS_EN
  ,
  output logic [31:0]                         stat_issued,
  output logic [31:0]                         stat_dropped
`endif
);

  logic                      win_val;
  logic [p_seq_num_bits-1:0] win_age;
  logic [p_target_bits-1:0]  win_target;
  logic [p_seq_num_bits-1:0] win_seq;
  logic [p_seq_num_bits-1:0] req_age;
  logic [p_seq_num_bits-1:0] pend_age;
  logic                      xfer;
  logic                      load;

  // Modular distance from the head; strict compare keeps the lowest index on ties.
  always_comb begin
    win_val    = 1'b0;
    win_age    = '0;
    win_target = '0;
    win_seq    = '0;
    req_age    = '0;
    for (int i = 0; i < p_num_req; i++) begin
      req_age = req_seq_num[i*p_seq_num_bits +: p_seq_num_bits] - head_seq_num;
      if (req_val[i] && (!win_val || (req_age < win_age))) begin
        win_val    = 1'b1;
        win_age    = req_age;
        win_target = req_target[i*p_target_bits +: p_target_bits];
        win_seq    = req_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
      end
    end
  end

  assign pend_age = sq_seq_num - head_seq_num;
  assign xfer     = sq_val & sq_rdy;
  assign load     = win_val & (!sq_val | xfer | (win_age < pend_age));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_val     <= 1'b0;
      sq_target  <= '0;
      sq_seq_num <= '0;
    end else if (load) begin
      sq_val     <= 1'b1;
      sq_target  <= win_target;
      sq_seq_num <= win_seq;
    end else if (xfer) begin
      sq_val     <= 1'b0;
    end
  end

`ifdef SQUASH_ARB_STATS_EN
  logic [3:0] req_count;

  always_comb begin
    req_count = '0;
    for (int i = 0; i < p_num_req; i++) begin
      req_count = req_count + {3'd0, req_val[i]};
    end
  end

  // Every valid request that did not become the pending squash counts as dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued  <= '0;
      stat_dropped <= '0;
    end else begin
      stat_issued  <= stat_issued + {31'd0, xfer};
      stat_dropped <= stat_dropped + {28'd0, req_count} - {31'd0, load};
    end
  end
`endif

endmodule

// File: tb/tb_squash_arbiter_l6.sv
// Directed bench for squash_arbiter_l6: arbitration, replacement, wrap, transfer and async reset.
module tb_squash_arbiter_l6;

  logic        clk;
  logic        rst;
  logic [4:0]  head_seq_num;
  logic [1:0]  req_val;
  logic [63:0] req_target;
  logic [9:0]  req_seq_num;
  logic        sq_val;
  logic        sq_rdy;
  logic [31:0] sq_target;
  logic [4:0]  sq_seq_num;
`ifdef SQUASH_ARB_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_dropped;
`endif

  int compared   = 0;
  int mismatched = 0;

  squash_arbiter_l6 dut (
    .clk          (clk),
    .rst          (rst),
    .head_seq_num (head_seq_num),
    .req_val      (req_val),
    .req_target   (req_target),
    .req_seq_num  (req_seq_num),
    .sq_val       (sq_val),
    .sq_rdy       (sq_rdy),
    .sq_target    (sq_target),
    .sq_seq_num   (sq_seq_num)
`ifdef SQUASH_ARB_STATS_EN
    ,
    .stat_issued  (stat_issued),
    .stat_dropped (stat_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic [4:0] head, input logic rdy,
                               input logic v0, input logic [4:0] s0, input logic [31:0] t0,
                               input logic v1, input logic [4:0] s1, input logic [31:0] t1);
    head_seq_num = head;
    sq_rdy       = rdy;
    req_val      = {v1, v0};
    req_seq_num  = {s1, s0};
    req_target   = {t1, t0};
    @(posedge clk);
    #1;
    req_val = 2'b00;
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic full,
                             input logic [4:0] es, input logic [31:0] et);
    compare({tag, "_val"}, {31'd0, sq_val}, {31'd0, ev});
    if (full) begin
      compare({tag, "_seq"}, {27'd0, sq_seq_num}, {27'd0, es});
      compare({tag, "_tgt"}, sq_target, et);
    end
  endtask

  task automatic checkStats(input string tag, input logic [31:0] ei, input logic [31:0] ed);
`ifdef SQUASH_ARB_STATS_EN
    compare({tag, "_issued"}, stat_issued, ei);
    compare({tag, "_dropped"}, stat_dropped, ed);
`else
    if (tag.len() == 0) $display("[TB] %0h %0h", ei, ed);
`endif
  endtask

  initial begin
    rst          = 1'b1;
    head_seq_num = '0;
    sq_rdy       = 1'b0;
    req_val      = '0;
    req_seq_num  = '0;
    req_target   = '0;
    #2;
    checkOutput("reset", 1'b0, 1'b1, 5'd0, 32'h0);
    checkStats("reset", 32'd0, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("post_reset_idle", 1'b0, 1'b1, 5'd0, 32'h0);

    // Single request, consumer ready
    applyStimulus(5'd0, 1'b1, 1'b1, 5'd5, 32'h100, 1'b0, 5'd0, 32'h0);
    checkOutput("single", 1'b1, 1'b1, 5'd5, 32'h100);
    applyStimulus(5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("single_drain", 1'b0, 1'b0, 5'd0, 32'h0);
    checkStats("single", 32'd1, 32'd0);

    // Simultaneous: head=2, ages 7 and 2
    applyStimulus(5'd2, 1'b0, 1'b1, 5'd9, 32'h200, 1'b1, 5'd4, 32'h300);
    checkOutput("simul", 1'b1, 1'b1, 5'd4, 32'h300);
    checkStats("simul", 32'd1, 32'd1);
    applyStimulus(5'd2, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("simul_drain", 1'b0, 1'b0, 5'd0, 32'h0);

    // Replacement under backpressure
    applyStimulus(5'd0, 1'b0, 1'b1, 5'd10, 32'hA00, 1'b0, 5'd0, 32'h0);
    checkOutput("repl_load", 1'b1, 1'b1, 5'd10, 32'hA00);
    applyStimulus(5'd0, 1'b0, 1'b1, 5'd7, 32'h700, 1'b0, 5'd0, 32'h0);
    checkOutput("repl_older", 1'b1, 1'b1, 5'd7, 32'h700);
    applyStimulus(5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC00);
    checkOutput("repl_younger", 1'b1, 1'b1, 5'd7, 32'h700);
    checkStats("repl_younger", 32'd2, 32'd2);
    applyStimulus(5'd0, 1'b0, 1'b1, 5'd7, 32'h777, 1'b0, 5'd0, 32'h0);
    checkOutput("repl_equal", 1'b1, 1'b1, 5'd7, 32'h700);
    applyStimulus(5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("repl_drain", 1'b0, 1'b0, 5'd0, 32'h0);
    checkStats("repl_drain", 32'd3, 32'd3);

    // Wrap: head=30 -> seq 31 (age 1) beats seq 1 (age 3)
    applyStimulus(5'd30, 1'b0, 1'b1, 5'd1, 32'h111, 1'b1, 5'd31, 32'h131);
    checkOutput("wrap30", 1'b1, 1'b1, 5'd31, 32'h131);
    applyStimulus(5'd30, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("wrap30_drain", 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(5'd0, 1'b0, 1'b1, 5'd1, 32'h111, 1'b1, 5'd31, 32'h131);
    checkOutput("wrap0", 1'b1, 1'b1, 5'd1, 32'h111);
    checkStats("wrap0", 32'd4, 32'd5);
    applyStimulus(5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("wrap0_drain", 1'b0, 1'b0, 5'd0, 32'h0);

    // Transfer and new (younger) request in the same cycle
    applyStimulus(5'd0, 1'b0, 1'b1, 5'd3, 32'h303, 1'b0, 5'd0, 32'h0);
    checkOutput("xfer_pend", 1'b1, 1'b1, 5'd3, 32'h303);
    applyStimulus(5'd0, 1'b1, 1'b1, 5'd20, 32'h2000, 1'b0, 5'd0, 32'h0);
    checkOutput("xfer_load", 1'b1, 1'b1, 5'd20, 32'h2000);
    checkStats("xfer_load", 32'd6, 32'd5);
    applyStimulus(5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("xfer_hold", 1'b1, 1'b1, 5'd20, 32'h2000);

    // Equal ages on both requesters go to index 0
    applyStimulus(5'd0, 1'b1, 1'b1, 5'd9, 32'h901, 1'b1, 5'd9, 32'h902);
    checkOutput("tie", 1'b1, 1'b1, 5'd9, 32'h901);
    checkStats("tie", 32'd7, 32'd6);
    applyStimulus(5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("tie_hold", 1'b1, 1'b1, 5'd9, 32'h901);

    // Asynchronous reset between edges while holding
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst", 1'b0, 1'b1, 5'd0, 32'h0);
    checkStats("async_rst", 32'd0, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("after_rst_idle", 1'b0, 1'b1, 5'd0, 32'h0);
    applyStimulus(5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h222);
    checkOutput("after_rst_load", 1'b1, 1'b1, 5'd2, 32'h222);
    checkStats("after_rst_load", 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/squash_arbiter_l6.md
Name: squash_arbiter_l6

Overview:
- Collects squash notifications from all control-flow execute units in the L6 execute stage.
- Selects the oldest by sequence number, with age measured relative to the in-flight head.
- Holds the selected squash in a single pending register and presents it to fetch/decode over a val/rdy handshake.
- An older squash arriving later replaces the pending one. A younger or equal-age squash is discarded, since the pending squash already covers it.

Parameters:
- p_num_req, 2, number of squash requesters (1..8)
- p_seq_num_bits, 5, sequence number width
- p_target_bits, 32, redirect target width

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- head_seq_num  input  p_seq_num_bits  sequence number of the oldest in-flight instruction; age reference
- req_val  input  p_num_req  per-requester squash valid
- req_target  input  p_num_req*p_target_bits  flattened targets; requester i at bits [i*p_target_bits +: p_target_bits]
- req_seq_num  input  p_num_req*p_seq_num_bits  flattened sequence numbers, same packing
- sq_val  output  1  pending squash valid
- sq_rdy  input  1  consumer accepts squash
- sq_target  output  p_target_bits  redirect target of pending squash
- sq_seq_num  output  p_seq_num_bits  sequence number of squashing instruction
- (`SQUASH_ARB_STATS_EN` only) stat_issued  output  32  squashes transferred
- (`SQUASH_ARB_STATS_EN` only) stat_dropped  output  32  requests discarded

Behaviour:
- Age: age_i = (req_seq_num_i - head_seq_num) mod 2^p_seq_num_bits, unsigned. Smaller age is older. Pending age is computed the same way against the current head_seq_num every cycle.
- Winner: among valid requesters, the minimum age wins. Ties go to the lowest index. Selection is purely combinational.
- State is one pending register {val, target, seq_num}. There is no other state apart from the optional stat counters.
- Transfer: xfer = sq_val & sq_rdy.
- Next-state priority, per cycle:
  1. No winner: if xfer, clear val; else hold.
  2. Winner and (pending invalid or xfer): load winner, val=1.
  3. Winner and pending valid, no xfer, winner age < pending age: replace pending with winner.
  4. Otherwise: hold pending; winner is discarded.
- Latency: a request at cycle N is visible on sq_* at cycle N+1. No combinational path from req_* to sq_*.
- sq_val stays high until transferred. sq_target and sq_seq_num change while sq_val is high only on a replacement (rule 3).
- sq_rdy does not depend on sq_val combinationally. sq_rdy high with sq_val low is a no-op.
- Non-winning valid requesters are always discarded. Requesters hold their squash valid for exactly one cycle; the arbiter does not backpressure them.
- Sequence-number wrap: age arithmetic handles wrap, e.g. head=30 (5-bit), seq 1 has age 3 and is older than seq 31 (age 1)? No: seq 31 age 1 is older. Correct ordering is required across the 31→0 boundary.
- Reset (asynchronous, any time, including mid-hold): pending val=0, target=0, seq_num=0. All outputs read 0 while rst is high and after release until the first load.
- head_seq_num advancing past the pending seq_num is not legal upstream. No check is required.

Optional Feature:
- Macro `SQUASH_ARB_STATS_EN`.
- Defined: two 32-bit counters, both reset to 0 and wrapping at 2^32.
  - stat_issued increments on each xfer.
  - stat_dropped adds the count of valid requests not loaded that cycle: losers, plus a winner discarded by rule 4.
  - Both counters are exposed on the stat_* ports.
- Undefined: stat_* ports and counters are absent. Core behaviour is identical.

Test Plan:
- Single request: head=0, req0 val seq=5 target=0x100 at cycle 1, sq_rdy=1 → sq_val=1, sq_seq_num=5, sq_target=0x100 at cycle 2; sq_val=0 at cycle 3.
- Simultaneous: head=2, req0 seq=9 target=0x200, req1 seq=4 target=0x300 → sq_seq_num=4, sq_target=0x300; stat_dropped=1 with `SQUASH_ARB_STATS_EN`.
- Replacement under backpressure: sq_rdy=0, head=0, pending seq=10.
  - req0 seq=7 → pending becomes 7.
  - Then req1 seq=12 → pending stays 7; stat_dropped=1.
- Wrap: head=30 (5-bit), req0 seq=1, req1 seq=31 same cycle → seq 31 selected. Repeat with head=0 → seq 1 selected.
- Transfer plus new request same cycle: pending seq=3 with sq_rdy=1, req0 seq=20 arrives → next cycle sq_val=1, sq_seq_num=20; stat_issued increments by 1.
- Async reset mid-hold: pending valid with sq_rdy=0, assert rst between clock edges → sq_val=0 immediately with no clock edge; counters read 0.
